// File: rtl/load_pkg.sv
// ============================================================================
// load_pkg : load opcodes, FSM states and alignment helper   | rev 1.0
// ============================================================================
`default_nettype none

package load_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LWL = 3'b010,
    OP_LW  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_LWR = 3'b110,
    OP_ILL = 3'b111
  } load_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ      = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_FAULT     = 2'd3
  } load_state_t;

  // Alignment only; the illegal opcode is screened separately by the caller.
  function automatic logic is_misaligned(input load_op_t op, input logic [1:0] offset);
    case (op)
      OP_LH, OP_LHU: is_misaligned = offset[0];
      OP_LW:         is_misaligned = (offset != 2'b00);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// load_align : byte-lane select, extension and LWL/LWR merge  | rev 1.0
// ============================================================================
`default_nettype none

module load_align
  import load_pkg::*;
(
  input  load_op_t    i_op,
  input  logic [1:0]  i_k,
  input  logic [31:0] i_word,
  input  logic [31:0] i_rt_value,
  output logic [31:0] o_data,
  output logic [3:0]  o_byteenable
);

  logic [4:0]  w_sh_r;
  logic [4:0]  w_sh_l;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // ~k equals 3-k for a 2-bit offset, giving the LWL left-shift distance.
  assign w_sh_r    = {i_k, 3'b000};
  assign w_sh_l    = {~i_k, 3'b000};
  assign w_shifted = i_word >> w_sh_r;
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_k[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data       = 32'h0;
    o_byteenable = 4'b0000;
    case (i_op)
      OP_LB: begin
        o_data       = {{24{w_byte[7]}}, w_byte};
        o_byteenable = 4'b0001 << i_k;
      end
      OP_LBU: begin
        o_data       = {24'h0, w_byte};
        o_byteenable = 4'b0001 << i_k;
      end
      OP_LH: begin
        o_data       = {{16{w_half[15]}}, w_half};
        o_byteenable = i_k[1] ? 4'b1100 : 4'b0011;
      end
      OP_LHU: begin
        o_data       = {16'h0, w_half};
        o_byteenable = i_k[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        o_data       = i_word;
        o_byteenable = 4'b1111;
      end
      OP_LWL: begin
        o_data       = (i_word << w_sh_l) | (i_rt_value & ~(32'hFFFF_FFFF << w_sh_l));
        o_byteenable = 4'b1111 >> (~i_k);
      end
      OP_LWR: begin
        o_data       = (i_word >> w_sh_r) | (i_rt_value & ~(32'hFFFF_FFFF >> w_sh_r));
        o_byteenable = 4'b1111 << i_k;
      end
      default: begin
        o_data       = 32'h0;
        o_byteenable = 4'b0000;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_writeback_unit.sv
// ============================================================================
// load_writeback_unit : multi-cycle load engine driving the RF write port | rev 1.0
// ============================================================================
`default_nettype none

module load_writeback_unit
  import load_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [4:0]  i_req_rt,
  input  logic [31:0] i_req_rt_value,
  output logic [31:0] o_mem_address,
  output logic        o_mem_read,
  output logic [3:0]  o_mem_byteenable,
  input  logic        i_mem_waitrequest,
  input  logic [31:0] i_mem_readdata,
  output logic        o_reg_write,
  output logic [4:0]  o_reg_write_addr,
  output logic [31:0] o_reg_data,
  output logic        o_done,
  output logic        o_addr_error
);

  load_state_t r_state;
  load_state_t w_state_next;
  load_op_t    r_op;
  logic [31:0] r_addr;
  logic [4:0]  r_rt;
  logic [31:0] r_rt_value;
  logic [31:0] r_word;

  load_op_t    w_req_op;
  logic        w_fault;
  logic [31:0] w_data;
  logic [3:0]  w_be;

  assign w_req_op = load_op_t'(i_req_op);
  assign w_fault  = (w_req_op == OP_ILL) || is_misaligned(w_req_op, i_req_addr[1:0]);

  load_align u_align (
    .i_op         (r_op),
    .i_k          (r_addr[1:0]),
    .i_word       (r_word),
    .i_rt_value   (r_rt_value),
    .o_data       (w_data),
    .o_byteenable (w_be)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    o_req_ready      = 1'b0;
    o_mem_read       = 1'b0;
    o_mem_byteenable = 4'b0000;
    o_mem_address    = {r_addr[31:2], 2'b00};
    o_reg_write      = 1'b0;
    o_reg_write_addr = 5'd0;
    o_reg_data       = 32'h0;
    o_done           = 1'b0;
    o_addr_error     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_state_next = w_fault ? ST_FAULT : ST_READ;
      end
      ST_READ: begin
        o_mem_read       = 1'b1;
        o_mem_byteenable = w_be;
        if (!i_mem_waitrequest) w_state_next = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        // $zero is architecturally hard-wired, so its write is dropped here.
        o_reg_write      = (r_rt != 5'd0);
        o_reg_write_addr = r_rt;
        o_reg_data       = w_data;
        o_done           = 1'b1;
        w_state_next     = ST_IDLE;
      end
      ST_FAULT: begin
        o_done       = 1'b1;
        o_addr_error = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op       <= OP_LB;
      r_addr     <= 32'h0;
      r_rt       <= 5'd0;
      r_rt_value <= 32'h0;
      r_word     <= 32'h0;
    end else begin
      if (r_state == ST_IDLE && i_req_valid) begin
        r_op       <= w_req_op;
        r_addr     <= i_req_addr;
        r_rt       <= i_req_rt;
        r_rt_value <= i_req_rt_value;
      end
      if (r_state == ST_READ && !i_mem_waitrequest) r_word <= i_mem_readdata;
    end
  end

endmodule

`default_nettype wire

// File: doc/load_writeback_unit.md
# load_writeback_unit

Multi-cycle load engine for the MIPS datapath, acting as the initiator of the register-file write port. It accepts one load request at a time, issues a single word read on the Avalon-style data bus (honouring `mem_waitrequest`), aligns and sign-/zero-extends the returned bytes, and merges with the old `rt` value for LWL/LWR. It then drives a one-cycle register write. It sits between the decode/execute stage and the register file, and owns all load-type writebacks.

## Interface
Parameters:
- None; widths are fixed by the ISA (32-bit data/address, 5-bit register index).

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in 1: load request present.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_op` in 3: opcode[2:0]. LB=000, LH=001, LWL=010, LW=011, LBU=100, LHU=101, LWR=110. 111 is illegal.
- `req_addr` in 32: effective byte address.
- `req_rt` in 5: destination register.
- `req_rt_value` in 32: current `rt` contents, used by LWL/LWR.
- `mem_address` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_read` out 1: read strobe.
- `mem_byteenable` out 4: byte lanes requested.
- `mem_waitrequest` in 1: slave stall.
- `mem_readdata` in 32: valid in a cycle with `mem_read` high and `mem_waitrequest` low.
- `reg_write` out 1: register-file write enable.
- `reg_write_addr` out 5: register-file write index.
- `reg_data` out 32: register-file write data.
- `done` out 1: one-cycle pulse when a load completes or faults.
- `addr_error` out 1: one-cycle pulse on a misaligned or illegal request, coincident with `done`.

## Operation
- **Byte order:** little-endian. Byte offset k = `req_addr[1:0]` maps to `mem_readdata[8k+7:8k]`.
- **FSM states:** IDLE, READ, WRITEBACK, FAULT. All outputs are Moore, decoded from the state and captured registers.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, capture op, addr, rt and rt_value.
  - Misaligned request (LH/LHU with odd k, LW with k≠0) or `req_op`=111 → FAULT. Otherwise → READ.
- **READ:**
  - `mem_read`=1; address and byteenable are held constant.
  - While `mem_waitrequest`=1, stay in READ.
  - When `mem_waitrequest`=0, capture `mem_readdata` → WRITEBACK.
- **WRITEBACK:**
  - `reg_write`=1 unless rt==0, in which case it is suppressed.
  - `done`=1 → IDLE.
- **FAULT:** `done`=1, `addr_error`=1, no memory access, no register write → IDLE.
- **Byteenable:**
  - LB/LBU: one-hot bit k.
  - LH/LHU: 0011 or 1100.
  - LW: 1111.
  - LWL: bits 0..k.
  - LWR: bits k..3.
- **Data shaping** (W = captured word, R = captured rt_value):
  - LB/LBU: byte k, sign-/zero-extended to 32 bits.
  - LH/LHU: halfword at k, sign-/zero-extended.
  - LW: W.
  - LWL: `(W << 8*(3-k)) | (R & ((1<<8*(3-k))-1))`.
  - LWR: `(W >> 8*k) | (R & ~(32'hFFFFFFFF >> 8*k))`.
- Outside WRITEBACK, `reg_data` and `reg_write_addr` may hold any value, but `reg_write` must be 0.

## Timing
- **Reset:** on a rising edge with `reset`=1, state → IDLE. Outputs after reset:
  - `req_ready`=1.
  - `mem_read`=0, `reg_write`=0, `done`=0, `addr_error`=0.
  - `mem_address`=0, `mem_byteenable`=0.
  - `reg_write_addr`=0, `reg_data`=0.
- **Zero-wait latency:** request accepted at edge N. `mem_read` is high in cycle N..N+1, `reg_write` and `done` are high in cycle N+1..N+2, and `req_ready` returns in N+2..N+3.
  - Each waitrequest cycle adds one cycle.
  - Fault path: `done` is high in the cycle after acceptance.
- The register file commits on the falling edge inside the WRITEBACK cycle, so a dependent read is valid from the following rising edge.
- **Reset mid-operation:** abandons READ or WRITEBACK immediately. No write occurs; `mem_read` drops at the reset edge. The whole system resets together, so the bus abort is acceptable.
- **Back-to-back requests:** minimum spacing is 3 cycles. `req_valid` is ignored while `req_ready`=0.
- **Throughput:** at most one outstanding read; `mem_address` never changes while `mem_read`=1.

## Structure
- Package `load_pkg`:
  - Enum `load_op_t` with the 3-bit encodings above.
  - Enum `load_state_t` with IDLE/READ/WRITEBACK/FAULT.
  - Function `is_misaligned(op, offset)`.
- Sub-module `load_align`: purely combinational. Inputs op, k, W, R; outputs shaped data and byteenable. It is shared by the FSM for byteenable generation and for writeback data.
- Top level: FSM, capture registers and output decode.

## Test plan
- LW at 0x100, zero wait, readdata 0x44332211, rt=2 → `mem_byteenable`=1111; `reg_write` with addr 2, data 0x44332211, at cycle N+1; `done` pulse.
- LB / LBU at 0x103, readdata 0x80332211, 3 waitrequest cycles → data 0xFFFFFF80 / 0x00000080; `reg_write` asserted exactly 4 cycles after `mem_read` rises.
- LWL at 0x101 and LWR at 0x101, W=0x44332211, R=0xAABBCCDD → 0x2211CCDD with byteenable 0011; 0xAA443322 with byteenable 1110.
- LH at 0x101, LW at 0x102, op=111 → `addr_error` and `done` pulse; `mem_read` never asserted; `reg_write` stays 0.
- LW with rt=0 → `mem_read` asserted and read completes, `done` pulses, `reg_write` stays 0.
- `reset` asserted during READ with `mem_waitrequest` held high → next cycle IDLE, `mem_read`=0, `req_ready`=1, no `reg_write` ever asserted.
